// File: rtl/alarm_ringer.sv
// alarm_ringer: alarm sounder with snooze handling.
// States IDLE / RING / SNOOZE. A sub-second counter driven by 'tick'
// produces a one-cycle second strobe; the buzzer is on during the first
// half of every second while ringing.
// Optional feature macro RINGER_TIMEOUT_EN: when defined, RING returns to
// IDLE on the second strobe that completes RING_TIMEOUT_S seconds of
// continuous ringing. When undefined, RING lasts until stop, snooze or
// enable low.
module alarm_ringer #(
    parameter int TICKS_PER_SEC  = 10,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       trigger,
    input  logic       tick,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_count,
    output logic [8:0] snooze_left,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    localparam logic [7:0] SUB_LAST = 8'(TICKS_PER_SEC - 1);
    localparam logic [7:0] SUB_HALF = 8'(TICKS_PER_SEC / 2);
    localparam logic [8:0] SNZ_LOAD = 9'(SNOOZE_S);
    localparam logic [2:0] SNZ_MAX  = 3'(MAX_SNOOZES);

    logic [1:0] state;
    logic [7:0] sub_cnt;
    logic       trig_q;
    logic       stop_q;
    logic       snz_q;
    logic       trig_edge;
    logic       stop_edge;
    logic       snz_edge;
    logic       sec_strobe;
    logic       ring_expire;

    // Only rising edges of the level inputs act; the previous-value
    // registers start at 0 so a trigger already high at reset release
    // is seen as an edge.
    assign trig_edge  = trigger & ~trig_q;
    assign stop_edge  = stop_btn & ~stop_q;
    assign snz_edge   = snooze_btn & ~snz_q;
    assign sec_strobe = tick && (sub_cnt == SUB_LAST);

`ifdef RINGER_TIMEOUT_EN
    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

    logic [7:0] ring_sec;

    assign ring_expire = sec_strobe && (ring_sec == RING_LAST);

    // Whole seconds spent in the current ring burst; held at 0 outside
    // RING so every entry into RING starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ring_sec <= 8'd0;
        end else if (state != ST_RING) begin
            ring_sec <= 8'd0;
        end else if (sec_strobe) begin
            ring_sec <= ring_sec + 8'd1;
        end
    end
`else
    assign ring_expire = 1'b0;
`endif

    // Previous-value registers for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_q <= 1'b0;
            stop_q <= 1'b0;
            snz_q  <= 1'b0;
        end else begin
            trig_q <= trigger;
            stop_q <= stop_btn;
            snz_q  <= snooze_btn;
        end
    end

    // Main FSM with sub-second counter and snooze bookkeeping. Branch
    // order encodes priority: enable low, stop, snooze, expiry, ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sub_cnt      <= 8'd0;
            snooze_count <= 3'd0;
            snooze_left  <= 9'd0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            sub_cnt     <= 8'd0;
            snooze_left <= 9'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sub_cnt <= 8'd0;
                    if (trig_edge) begin
                        state        <= ST_RING;
                        snooze_count <= 3'd0;
                    end
                end
                ST_RING: begin
                    if (stop_edge) begin
                        state   <= ST_IDLE;
                        sub_cnt <= 8'd0;
                    end else if (snz_edge && (snooze_count < SNZ_MAX)) begin
                        state        <= ST_SNOOZE;
                        sub_cnt      <= 8'd0;
                        snooze_count <= snooze_count + 3'd1;
                        snooze_left  <= SNZ_LOAD;
                    end else if (ring_expire) begin
                        state   <= ST_IDLE;
                        sub_cnt <= 8'd0;
                    end else if (sec_strobe) begin
                        sub_cnt <= 8'd0;
                    end else if (tick) begin
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_edge) begin
                        state       <= ST_IDLE;
                        sub_cnt     <= 8'd0;
                        snooze_left <= 9'd0;
                    end else if (sec_strobe) begin
                        sub_cnt <= 8'd0;
                        if (snooze_left == 9'd1) begin
                            state       <= ST_RING;
                            snooze_left <= 9'd0;
                        end else begin
                            snooze_left <= snooze_left - 9'd1;
                        end
                    end else if (tick) begin
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    sub_cnt     <= 8'd0;
                    snooze_left <= 9'd0;
                end
            endcase
        end
    end

    // Output decode straight from registered state and counter.
    assign ringing   = (state == ST_RING);
    assign snoozing  = (state == ST_SNOOZE);
    assign buzzer    = ringing && (sub_cnt < SUB_HALF);
    assign state_dbg = state;

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 10, number of tick pulses per second (even, 2..255).
REQ-002 SHALL have parameter RING_TIMEOUT_S, default 60, seconds of continuous ringing before auto-stop (1..255).
REQ-003 SHALL have parameter SNOOZE_S, default 300, snooze length in seconds (1..511).
REQ-004 SHALL have parameter MAX_SNOOZES, default 3, snoozes allowed per alarm event (0..7).
REQ-005 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable  input  1  alarm armed; low forces idle.
REQ-008 SHALL have port trigger  input  1  level match flag from the alarm comparator; sustained high.
REQ-009 SHALL have port tick  input  1  one-clk pulse, TICKS_PER_SEC per second.
REQ-010 SHALL have port stop_btn  input  1  raw level, debounced upstream.
REQ-011 SHALL have port snooze_btn  input  1  raw level, debounced upstream.
REQ-012 SHALL have port buzzer  output  1  audible drive, pulsed pattern.
REQ-013 SHALL have port ringing  output  1  high in RING.
REQ-014 SHALL have port snoozing  output  1  high in SNOOZE.
REQ-015 SHALL have port snooze_count  output  3  snoozes used in current event.
REQ-016 SHALL have port snooze_left  output  9  seconds remaining in SNOOZE, 0 elsewhere.

Function
REQ-017 SHALL detect rising edges of trigger, stop_btn and snooze_btn by a registered previous-value compare; only edges act.
REQ-018 SHALL implement states IDLE, RING, SNOOZE, with ringing/snoozing a direct decode of state.
REQ-019 SHALL keep a sub-second counter 0..TICKS_PER_SEC-1, advanced on tick; wrap yields a one-cycle second strobe; counter cleared on every state entry.
REQ-020 IDLE: trigger edge with enable high -> RING next cycle; ring seconds and snooze_count cleared to 0.
REQ-021 RING: stop edge -> IDLE; snooze edge with snooze_count < MAX_SNOOZES -> SNOOZE, snooze_count +1, snooze_left loaded SNOOZE_S; snooze edge at limit ignored.
REQ-022 SNOOZE: snooze_left decrements on second strobe; strobe while snooze_left == 1 -> RING with ring seconds cleared; stop edge -> IDLE; snooze edge ignored.
REQ-023 Priority per cycle: enable low > stop edge > snooze edge > timeout/expiry > tick counting.
REQ-024 Trigger edges in RING or SNOOZE SHALL be ignored; snooze_count holds its value in IDLE until the next event.
REQ-025 buzzer SHALL be high in RING while sub-second counter < TICKS_PER_SEC/2, else low; always low outside RING.
REQ-026 Outputs SHALL change only on clk edges; latency input edge -> state/output change is one cycle.

Reset
REQ-027 Reset SHALL force IDLE, buzzer/ringing/snoozing 0, snooze_count 0, snooze_left 0, all counters and edge registers 0, immediately and regardless of clk.
REQ-028 trigger high at reset release with enable high SHALL count as a rising edge.

Configuration
REQ-029 Macro RINGER_TIMEOUT_EN defined: RING -> IDLE on the second strobe that completes RING_TIMEOUT_S seconds in RING.
REQ-030 RINGER_TIMEOUT_EN undefined: no timeout logic; RING persists until stop, snooze or enable low.

Verification (TICKS_PER_SEC=4, RING_TIMEOUT_S=3, SNOOZE_S=2, MAX_SNOOZES=2, RINGER_TIMEOUT_EN defined)
REQ-031 enable=1, trigger 0->1 -> ringing=1 next cycle; buzzer high for ticks 0-1, low for ticks 2-3 of each second.
REQ-032 Ringing, no buttons, 12 ticks -> ringing=0, buzzer=0 after 12th tick; without macro still ringing after 40 ticks.
REQ-033 Ringing, snooze edge -> snoozing=1, snooze_left=2, count=1; after 4 ticks snooze_left=1; after 8 ticks ringing=1, snooze_left=0.
REQ-034 Two snoozes used, third snooze edge -> stays RING, snooze_count=2.
REQ-035 stop and snooze edges same cycle while RING -> IDLE, snooze_count unchanged; enable dropped in SNOOZE -> IDLE next cycle.
REQ-036 Reset asserted mid-SNOOZE between clk edges -> all outputs 0 immediately; trigger held high at release -> RING one cycle later.
